wtm_pipe: RTL and testbench
===========================

WTM_PIPE -- requirements
Module: wtm_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand width in bits; legal range 4..32.
REQ-002 Parameter STAGES, default 3, sets the pipeline depth in register stages; legal values 2, 3, 4.
REQ-003 clock  input  1  sole clock; all state changes on the rising edge.
REQ-004 resetn  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operand pair present on this cycle.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 in1  input  WIDTH  multiplicand.
REQ-008 in2  input  WIDTH  multiplier.
REQ-009 is_signed  input  1  operands are two's complement when 1, unsigned when 0; sampled with the operands.
REQ-010 out_valid  output  1  result, ovf and tag_out are valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  2*WIDTH  full-precision product.
REQ-013 ovf  output  1  product does not fit in WIDTH bits under the sampled mode.
REQ-014 tag_in  input  4  user tag travelling with the operands.
REQ-015 tag_out  output  4  tag of the operand pair whose product is on result.

Function
REQ-016 Input handshake: a transfer occurs on a rising edge where in_valid=1 and in_ready=1; in1, in2, is_signed and tag_in are captured together.
REQ-017 Output handshake: a transfer completes on a rising edge where out_valid=1 and out_ready=1.
REQ-018 Pipeline advance: adv = ~out_valid | out_ready; in_ready equals adv combinationally; the pipeline is frozen while adv=0.
REQ-019 Each stage holds one valid bit; when adv=1, every stage loads from its predecessor, and stage 1 loads the valid bit (in_valid & in_ready).
REQ-020 Bubbles are not collapsed; an empty stage occupies one slot in the pipeline.
REQ-021 Latency: with out_ready held at 1, out_valid rises exactly STAGES cycles after the accepting edge; throughput is one product per cycle.
REQ-022 Stage 1 registers the partial-product matrix:
- WIDTH rows in unsigned mode.
- Baugh-Wooley sign-corrected rows in signed mode.
REQ-023 Intermediate stages hold Wallace-tree carry-save reductions using full and half adders; the 3:2 levels are divided as evenly as possible across stages 2..STAGES-1.
REQ-024 The final stage holds the carry-propagate sum of the two remaining rows, truncated to 2*WIDTH bits.
REQ-025 Unsigned mode: result = in1*in2; ovf = |result[2*WIDTH-1:WIDTH].
REQ-026 Signed mode: result = the two's-complement product; ovf = 1 unless result[2*WIDTH-1:WIDTH-1] is all zeros or all ones.
REQ-027 Boundary conditions:
- The signed product (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) is representable, gives ovf=1, and raises no error.
- Zero times any operand gives 0 with ovf=0.
REQ-028 While stalled (adv=0), result, ovf, tag_out and every stage register hold their values; input data is ignored.
REQ-029 Mode and tag are pipelined per transaction, so mixed signed and unsigned back-to-back operations are each computed correctly.
REQ-030 Datapath registers need no reset; only the valid bits are reset.

Reset
REQ-031 While resetn=0 at a rising edge, all stage valid bits clear; out_valid=0 from the next cycle.
REQ-032 During reset, in_ready=1 (since out_valid=0) and inputs are ignored; no transfer is accepted on a reset edge.
REQ-033 After reset, result, ovf and tag_out are don't-care until the first out_valid=1.
REQ-034 Reset asserted mid-operation discards all in-flight products; none appears after reset deasserts.

Verification
REQ-035 WIDTH=8, STAGES=3, out_ready=1:
- unsigned 18*2 -> result=0x0024, ovf=0, out_valid exactly 3 cycles after acceptance.
- 18*3 -> 0x0036.
REQ-036 Signed -3*5 (0xFD, 0x05) -> result=0xFFF1, ovf=0. Signed -128*-128 -> 0x4000, ovf=1. Unsigned 255*255 -> 0xFE01, ovf=1.
REQ-037 Back-to-back stream of 8 pairs with tags 0..7 and alternating is_signed, out_ready=1:
- 8 consecutive out_valid cycles, correct products, tag_out = 0..7 in order.
REQ-038 Stall: hold out_ready=0 for 5 cycles with the pipeline full:
- in_ready=0 throughout.
- result and tag_out are stable.
- On release, all products emerge in order with none lost or duplicated.
REQ-039 Reset: assert resetn=0 for 1 cycle with 2 products in flight -> out_valid=0 next cycle and no stale product ever appears; a new 7*9 then yields 0x003F.
REQ-040 Sweep all WIDTH=5 operand pairs in both modes, for STAGES=2 and STAGES=4, against a reference model -> zero mismatches.

Source files
------------

// File: rtl/wtm_pipe.sv
// wtm_pipe: pipelined Wallace-tree multiplier with valid/ready handshakes.
//   Stage 1 registers the partial-product matrix. Unsigned mode uses plain
//   rows; signed mode uses Baugh-Wooley sign-corrected rows. Stages
//   2..STAGES-1 hold carry-save (3:2) reductions. The final stage holds the
//   carry-propagate sum plus the overflow flag.
// Ports:
//   clock, resetn         - clock; synchronous active-low reset
//   in_valid/in_ready     - operand handshake (in_ready = ~out_valid | out_ready)
//   in1, in2, is_signed   - operands and mode, captured together
//   tag_in / tag_out      - 4-bit user tag carried with each product
//   out_valid/out_ready   - result handshake
//   result, ovf           - 2*WIDTH product; product does not fit in WIDTH bits
module wtm_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 3
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               ovf,
   input  logic [3:0]         tag_in,
   output logic [3:0]         tag_out
);

   localparam int unsigned W  = WIDTH;
   localparam int unsigned PW = 2 * W;
   // WIDTH partial-product rows plus one constant row for Baugh-Wooley
   localparam int unsigned NR = W + 1;

   typedef logic [PW-1:0]          row_t;
   typedef logic [NR-1:0][PW-1:0]  rows_t;

   // Row count left after one 3:2 level
   function automatic int unsigned rows_after(input int unsigned n);
      return (n / 3) * 2 + (n % 3);
   endfunction

   function automatic int unsigned num_levels();
      int unsigned n;
      int unsigned l;
      n = NR;
      l = 0;
      while (n > 2) begin
         n = rows_after(n);
         l++;
      end
      return l;
   endfunction

   localparam int unsigned NLVL = num_levels();
   localparam int unsigned MID  = STAGES - 2;

   // Levels completed by the end of intermediate stage k (stage k+1).
   // Rounded up so any uneven remainder lands in the earlier stages.
   function automatic int unsigned lvl_done(input int unsigned k);
      if (k == 0) return 0;
      if (MID == 0) return NLVL;
      return (NLVL * k + MID - 1) / MID;
   endfunction

   // One Wallace level: each group of three rows becomes a sum row and a
   // shifted carry row (full adders per bit; half adders where a row is 0).
   function automatic rows_t csa(input rows_t r, input int unsigned n);
      rows_t       o;
      row_t        a, b, c;
      int unsigned g;
      o = '0;
      g = n / 3;
      for (int unsigned j = 0; j < NR / 3; j++) begin
         if (j < g) begin
            a = r[3*j];
            b = r[3*j+1];
            c = r[3*j+2];
            o[2*j]   = a ^ b ^ c;
            o[2*j+1] = ((a & b) | (a & c) | (b & c)) << 1;
         end
      end
      for (int unsigned t = 0; t < 3; t++) begin
         if (t < n % 3) o[2*g+t] = r[3*g+t];
      end
      return o;
   endfunction

   // Apply levels [from, upto) of the tree to a row set
   function automatic rows_t reduce(input rows_t r, input int unsigned from,
                                    input int unsigned upto);
      rows_t       x;
      int unsigned n;
      x = r;
      n = NR;
      for (int unsigned l = 0; l < NLVL; l++) begin
         if (l >= from && l < upto) x = csa(x, n);
         n = rows_after(n);
      end
      return x;
   endfunction

   function automatic row_t add2(input rows_t r);
      return r[0] + r[1];
   endfunction

   logic                  adv;
   logic [STAGES:1]       vld_q;
   logic [STAGES-1:1]     sgn_q;
   logic [STAGES-1:1][3:0] tag_q;
   rows_t                 rows_q [1:STAGES-1];
   rows_t                 pp;
   row_t                  fsum;
   logic                  fovf;

   assign out_valid = vld_q[STAGES];
   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;

   // Partial-product matrix; signed mode inverts the bits where exactly one
   // factor is a sign bit, and adds 2^W + 2^(2W-1).
   always_comb begin
      pp = '0;
      for (int unsigned i = 0; i < W; i++) begin
         for (int unsigned j = 0; j < W; j++) begin
            pp[i][i+j] = (in1[j] & in2[i]) ^
                         (is_signed & ((i == W - 1) != (j == W - 1)));
         end
      end
      pp[W] = is_signed ? ((row_t'(1) << W) | (row_t'(1) << (PW - 1))) : '0;
   end

   always_comb begin
      fsum = add2(reduce(rows_q[STAGES-1], lvl_done(STAGES - 2), NLVL));
      if (sgn_q[STAGES-1])
         fovf = !((&fsum[PW-1:W-1]) | ~(|fsum[PW-1:W-1]));
      else
         fovf = |fsum[PW-1:W];
   end

   always_ff @(posedge clock) begin
      if (!resetn)
         vld_q <= '0;
      else if (adv)
         vld_q <= {vld_q[STAGES-1:1], in_valid & in_ready};
   end

   always_ff @(posedge clock) begin
      if (adv) begin
         rows_q[1] <= pp;
         sgn_q[1]  <= is_signed;
         tag_q[1]  <= tag_in;
         for (int unsigned s = 2; s < STAGES; s++) begin
            rows_q[s] <= reduce(rows_q[s-1], lvl_done(s - 2), lvl_done(s - 1));
            sgn_q[s]  <= sgn_q[s-1];
            tag_q[s]  <= tag_q[s-1];
         end
         result  <= fsum;
         ovf     <= fovf;
         tag_out <= tag_q[STAGES-1];
      end
   end

endmodule

// File: tb/tb_wtm_pipe.sv
// tb_wtm_pipe: scoreboard bench for wtm_pipe. Main instance WIDTH=8/STAGES=3
// gets directed, stall, reset and random traffic; two WIDTH=5 instances
// (STAGES=2 and 4) get an exhaustive operand sweep in both modes.
module tb_wtm_pipe;

   typedef struct {
      logic [63:0] res;
      logic        ovf;
      logic [3:0]  tag;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned nchk = 0;
   int unsigned nerr = 0;
   int unsigned cyc  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main DUT
   logic        resetn, in_valid, in_ready, is_signed, out_valid, out_ready, ovf;
   logic [7:0]  in1, in2;
   logic [15:0] result;
   logic [3:0]  tag_in, tag_out;

   // sweep DUTs share inputs
   logic        s_valid, s_sgn;
   logic [4:0]  s_in1, s_in2;
   logic [3:0]  s_tag;
   logic        s_oready;
   logic        r2_ready, r2_valid, r2_ovf, r4_ready, r4_valid, r4_ovf;
   logic [9:0]  r2_res, r4_res;
   logic [3:0]  r2_tag, r4_tag;

   wtm_pipe #(.WIDTH(8), .STAGES(3)) dut (
      .clock(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .is_signed(is_signed), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .ovf(ovf),
      .tag_in(tag_in), .tag_out(tag_out));

   wtm_pipe #(.WIDTH(5), .STAGES(2)) u2 (
      .clock(clk), .resetn(resetn), .in_valid(s_valid), .in_ready(r2_ready),
      .in1(s_in1), .in2(s_in2), .is_signed(s_sgn), .out_valid(r2_valid),
      .out_ready(s_oready), .result(r2_res), .ovf(r2_ovf),
      .tag_in(s_tag), .tag_out(r2_tag));

   wtm_pipe #(.WIDTH(5), .STAGES(4)) u4 (
      .clock(clk), .resetn(resetn), .in_valid(s_valid), .in_ready(r4_ready),
      .in1(s_in1), .in2(s_in2), .is_signed(s_sgn), .out_valid(r4_valid),
      .out_ready(s_oready), .result(r4_res), .ovf(r4_ovf),
      .tag_in(s_tag), .tag_out(r4_tag));

   // Reference: exact integer product, then range test for ovf
   function automatic exp_t model(input int unsigned w, input longint a,
                                  input longint b, input bit s,
                                  input logic [3:0] t);
      longint sa, sb, p, half;
      exp_t   e;
      half = longint'(1) << (w - 1);
      sa = (s && a >= half) ? a - (longint'(1) << w) : a;
      sb = (s && b >= half) ? b - (longint'(1) << w) : b;
      p  = sa * sb;
      e.res = p & ((longint'(1) << (2 * w)) - 1);
      e.ovf = s ? (p < -half || p >= half) : (p >= (longint'(1) << w));
      e.tag = t;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   exp_t q[$], q2[$], q4[$];
   int unsigned last_acc, last_out, run, max_run;
   logic [15:0] last_res;
   logic        last_ovf;

   // stimulus side: record expected response when a transfer is accepted
   always @(negedge clk) begin
      if (resetn !== 1'b1) begin
         q.delete(); q2.delete(); q4.delete();
      end else begin
         if (in_valid && in_ready) begin
            q.push_back(model(8, longint'(in1), longint'(in2), is_signed, tag_in));
            last_acc = cyc;
         end
         if (s_valid && r2_ready)
            q2.push_back(model(5, longint'(s_in1), longint'(s_in2), s_sgn, s_tag));
         if (s_valid && r4_ready)
            q4.push_back(model(5, longint'(s_in1), longint'(s_in2), s_sgn, s_tag));
      end
   end

   // monitor side
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (resetn === 1'b1 && out_valid === 1'b1 && out_ready) begin
         if (q.size() == 0) chk("main_unexpected_out", 1, 0);
         else begin
            e = q.pop_front();
            chk("main_result", result, e.res);
            chk("main_ovf", ovf, e.ovf);
            chk("main_tag", tag_out, e.tag);
            last_res = result; last_ovf = ovf; last_out = cyc;
         end
      end
      if (resetn === 1'b1 && r2_valid === 1'b1) begin
         if (q2.size() == 0) chk("s2_unexpected_out", 1, 0);
         else begin
            e = q2.pop_front();
            chk("s2_result", r2_res, e.res);
            chk("s2_ovf", r2_ovf, e.ovf);
            chk("s2_tag", r2_tag, e.tag);
         end
      end
      if (resetn === 1'b1 && r4_valid === 1'b1) begin
         if (q4.size() == 0) chk("s4_unexpected_out", 1, 0);
         else begin
            e = q4.pop_front();
            chk("s4_result", r4_res, e.res);
            chk("s4_ovf", r4_ovf, e.ovf);
            chk("s4_tag", r4_tag, e.tag);
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [3:0] t);
      bit acc;
      acc = 0;
      in1 = a; in2 = b; is_signed = s; tag_in = t; in_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready && resetn;
         @(posedge clk); #1;
      end
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      s_valid  = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 60; k++) begin
         if (q.size() == 0 && q2.size() == 0 && q4.size() == 0) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      chk("drain_pending", q.size() + q2.size() + q4.size(), 0);
   endtask

   function automatic logic [7:0] pick8();
      case ($urandom % 6)
         0: return 8'h00;
         1: return 8'hFF;
         2: return 8'h80;
         3: return 8'h7F;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in1 = '0; in2 = '0; is_signed = 1'b0; tag_in = '0;
      s_valid = 1'b0; s_sgn = 1'b0; s_in1 = '0; s_in2 = '0; s_tag = '0;
      s_oready = 1'b1;
      last_acc = 0; last_out = 0; run = 0; max_run = 0;
      last_res = '0; last_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_s2_valid", r2_valid, 0);
      chk("reset_s4_valid", r4_valid, 0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // directed products; latency counted in cycles from the accepting cycle
      send(8'd18, 8'd2, 1'b0, 4'd1); idle(); drain();
      chk("latency", last_out - last_acc, 3);
      chk("u18x2", last_res, 16'h0024);
      chk("u18x2_ovf", last_ovf, 0);
      send(8'd18, 8'd3, 1'b0, 4'd2); idle(); drain();
      chk("u18x3", last_res, 16'h0036);
      send(8'hFD, 8'h05, 1'b1, 4'd3); idle(); drain();
      chk("s_m3x5", last_res, 16'hFFF1);
      chk("s_m3x5_ovf", last_ovf, 0);
      send(8'h80, 8'h80, 1'b1, 4'd4); idle(); drain();
      chk("s_m128sq", last_res, 16'h4000);
      chk("s_m128sq_ovf", last_ovf, 1);
      send(8'hFF, 8'hFF, 1'b0, 4'd5); idle(); drain();
      chk("u255sq", last_res, 16'hFE01);
      chk("u255sq_ovf", last_ovf, 1);
      send(8'h00, 8'hA5, 1'b1, 4'd6); idle(); drain();
      chk("zero", last_res, 16'h0000);
      chk("zero_ovf", last_ovf, 0);

      // back-to-back stream, alternating mode
      max_run = 0;
      for (int i = 0; i < 8; i++) send(8'($urandom), 8'($urandom), 1'(i % 2), 4'(i));
      idle(); drain();
      chk("stream_consecutive", max_run, 8);

      // stall with the pipeline full
      send(8'd11, 8'd13, 1'b0, 4'd8);
      send(8'hF0, 8'd7, 1'b1, 4'd9);
      send(8'd200, 8'd3, 1'b0, 4'd10);
      out_ready = 1'b0;
      in1 = 8'd99; in2 = 8'd5; is_signed = 1'b0; tag_in = 4'd11; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_result", result, q[0].res);
         chk("stall_tag", tag_out, q[0].tag);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(8'd99, 8'd5, 1'b0, 4'd11); idle(); drain();

      // reset with two products in flight
      send(8'd50, 8'd60, 1'b0, 4'd12);
      send(8'd70, 8'd80, 1'b0, 4'd13);
      resetn = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("midreset_out_valid", out_valid, 0);
      resetn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      send(8'd7, 8'd9, 1'b0, 4'd14); idle(); drain();
      chk("post_reset_7x9", last_res, 16'h003F);

      // random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         in1 = pick8(); in2 = pick8();
         is_signed = 1'($urandom); tag_in = 4'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      drain();

      // exhaustive WIDTH=5 sweep, both modes
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++) begin
               s_valid = 1'b1; s_sgn = 1'(s);
               s_in1 = 5'(a); s_in2 = 5'(b); s_tag = 4'(a + b);
               @(posedge clk); #1;
            end
      idle(); drain();

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
